// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-scheduling controller.
// Imported by the controller and by neighbouring stages using the S memory.
package rc4_pkg;

    localparam int S_DEPTH = 256;
    localparam int DEF_KEY_BYTES = 3;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        RD_SI,
        WAIT_SI,
        LATCH_SI,
        CALC_J,
        RD_SJ,
        WAIT_SJ,
        LATCH_SJ,
        WR_I,
        WR_J,
        NEXT,
        DONE
    } ksa_state_t;

    function automatic int KEY_W(input int key_bytes);
        return 8 * key_bytes;
    endfunction

endpackage

// File: rtl/rc4_ksa_controller.sv
// RC4 key initialisation on the shared 256x8 S memory: identity fill,
// then key schedule with swaps; raises done_task2a when S is ready.
module rc4_ksa_controller
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = DEF_KEY_BYTES,
    parameter int READ_WAIT = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [KEY_W(KEY_BYTES)-1:0]   secret_key,
    output logic [7:0]                    address_s,
    output logic [7:0]                    data_s,
    output logic                          wren_s,
    input  logic [7:0]                    q_s,
    output logic                          done_task2a
);

    localparam int KIW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [7:0] LAST = 8'(S_DEPTH - 1);
    localparam logic [7:0] WLAST = 8'(READ_WAIT - 1);
    localparam logic [KIW-1:0] KLAST = KIW'(KEY_BYTES - 1);

    ksa_state_t     state_q, state_d;
    logic [7:0]     i_q, i_d;
    logic [7:0]     j_q, j_d;
    logic [KIW-1:0] kidx_q, kidx_d;
    logic [7:0]     si_q, si_d;
    logic [7:0]     sj_q, sj_d;
    logic [7:0]     wcnt_q, wcnt_d;
    logic [7:0]     addr_q, addr_d;
    logic [7:0]     data_q, data_d;
    logic           wren_q, wren_d;
    logic           done_q, done_d;
    logic [7:0]     key_b;

    // Byte 0 of the key sits in the most significant byte lane.
    always_comb begin
        key_b = '0;
        for (int k = 0; k < KEY_BYTES; k++) begin
            if (kidx_q == KIW'(k))
                key_b = secret_key[8*(KEY_BYTES-k)-1 -: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        kidx_d  = kidx_q;
        si_d    = si_q;
        sj_d    = sj_q;
        wcnt_d  = wcnt_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = INIT;
                    i_d     = '0;
                end
            end
            INIT: begin
                if (i_q == LAST) begin
                    state_d = RD_SI;
                    i_d     = '0;
                    j_d     = '0;
                    kidx_d  = '0;
                end else begin
                    i_d = i_q + 8'd1;
                end
            end
            RD_SI: begin
                wcnt_d  = '0;
                state_d = (READ_WAIT == 0) ? LATCH_SI : WAIT_SI;
            end
            WAIT_SI: begin
                wcnt_d = wcnt_q + 8'd1;
                if (wcnt_q == WLAST) state_d = LATCH_SI;
            end
            LATCH_SI: begin
                si_d    = q_s;
                state_d = CALC_J;
            end
            CALC_J: begin
                j_d     = j_q + si_q + key_b;
                state_d = RD_SJ;
            end
            RD_SJ: begin
                wcnt_d  = '0;
                state_d = (READ_WAIT == 0) ? LATCH_SJ : WAIT_SJ;
            end
            WAIT_SJ: begin
                wcnt_d = wcnt_q + 8'd1;
                if (wcnt_q == WLAST) state_d = LATCH_SJ;
            end
            LATCH_SJ: begin
                sj_d    = q_s;
                state_d = WR_I;
            end
            WR_I: state_d = WR_J;
            WR_J: state_d = NEXT;
            NEXT: begin
                if (i_q == LAST) begin
                    state_d = DONE;
                end else begin
                    i_d     = i_q + 8'd1;
                    kidx_d  = (kidx_q == KLAST) ? '0 : kidx_q + KIW'(1);
                    state_d = RD_SI;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the flops line up with it.
    always_comb begin
        addr_d = '0;
        data_d = '0;
        wren_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            INIT: begin
                addr_d = i_d;
                data_d = i_d;
                wren_d = 1'b1;
            end
            RD_SI, WAIT_SI, LATCH_SI: addr_d = i_d;
            RD_SJ, WAIT_SJ, LATCH_SJ: addr_d = j_d;
            WR_I: begin
                addr_d = i_d;
                data_d = sj_d;
                wren_d = 1'b1;
            end
            WR_J: begin
                addr_d = j_d;
                data_d = si_d;
                wren_d = 1'b1;
            end
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            kidx_q  <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            wcnt_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wren_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            kidx_q  <= kidx_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wren_q  <= wren_d;
            done_q  <= done_d;
        end
    end

    assign address_s   = addr_q;
    assign data_s      = data_q;
    assign wren_s      = wren_q;
    assign done_task2a = done_q;

endmodule

// File: tb/tb_rc4_ksa_controller.sv
// Directed bench for rc4_ksa_controller with a registered-address S memory
// and a software key-schedule reference.
module tb_rc4_ksa_controller;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [23:0] secret_key = '0;
    logic [7:0]  address_s;
    logic [7:0]  data_s;
    logic        wren_s;
    logic [7:0]  q_s;
    logic        done_task2a;

    always #5 clk = ~clk;

    rc4_ksa_controller dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .secret_key  (secret_key),
        .address_s   (address_s),
        .data_s      (data_s),
        .wren_s      (wren_s),
        .q_s         (q_s),
        .done_task2a (done_task2a)
    );

    logic [7:0] mem [256];
    logic [7:0] addr_r;

    always @(posedge clk) begin
        if (wren_s) mem[address_s] <= data_s;
        addr_r <= address_s;
    end
    assign q_s = mem[addr_r];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] wa [8192];
    logic [7:0] wd [8192];
    int         wc [8192];
    int         wn = 0;

    always @(negedge clk) begin
        if (wren_s && wn < 8192) begin
            wa[wn] = address_s;
            wd[wn] = data_s;
            wc[wn] = cyc;
            wn++;
        end
    end

    int total = 0;
    int bad = 0;
    logic [7:0] exp_s [256];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [23:0] key);
        logic [7:0] kb [3];
        logic [7:0] j;
        logic [7:0] t;
        kb[0] = key[23:16];
        kb[1] = key[15:8];
        kb[2] = key[7:0];
        for (int i = 0; i < 256; i++) exp_s[i] = 8'(i);
        j = '0;
        for (int i = 0; i < 256; i++) begin
            j = j + exp_s[i] + kb[i % 3];
            t = exp_s[i];
            exp_s[i] = exp_s[j];
            exp_s[j] = t;
        end
    endfunction

    task automatic check_s(input string tag, input logic [23:0] key);
        int n;
        n = 0;
        model(key);
        for (int k = 0; k < 256; k++)
            if (mem[k] !== exp_s[k]) n++;
        chk(tag, n, 0);
    endtask

    task automatic run(input logic [23:0] key, input int busy_at,
                       output int lat, output int wb, output logic d0);
        secret_key = key;
        @(negedge clk);
        start = 1'b1;
        wb = wn;
        @(posedge clk);
        #1;
        start = 1'b0;
        d0 = done_task2a;
        lat = 0;
        while (lat < 4000) begin
            @(posedge clk);
            lat++;
            #1;
            start = (lat == busy_at);
            if (done_task2a) break;
        end
        start = 1'b0;
    endtask

    function automatic logic [15:0] wpair(input int idx);
        return {wa[idx], wd[idx]};
    endfunction

    int   lat;
    int   wb;
    int   e;
    int   wn0;
    logic d0;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr", address_s, 0);
        chk("rst_data", data_s, 0);
        chk("rst_wren", wren_s, 0);
        chk("rst_done", done_task2a, 0);
        @(negedge clk);
        reset_n = 1'b1;

        run(24'h000000, -1, lat, wb, d0);
        e = 0;
        for (int k = 0; k < 256; k++) begin
            if (wa[wb+k] !== 8'(k) || wd[wb+k] !== 8'(k) || wc[wb+k] != wc[wb] + k)
                e++;
        end
        chk("init_sweep", e, 0);
        chk("init_end_gap", wc[wb+256] - wc[wb], 263);
        chk("z_wr_i0", wpair(wb+256), 16'h0000);
        chk("z_wr_j0", wpair(wb+257), 16'h0000);
        chk("z_wr_i2", wpair(wb+260), 16'h0203);
        chk("z_wr_j2", wpair(wb+261), 16'h0302);
        chk("z_latency", lat, 2816);
        chk("z_writes", wn - wb, 768);
        check_s("z_final_s", 24'h000000);

        run(24'h000001, -1, lat, wb, d0);
        chk("b_done_drop", d0, 0);
        chk("b_wr_i2", wpair(wb+260), 16'h0204);
        chk("b_wr_j2", wpair(wb+261), 16'h0402);
        chk("b_latency", lat, 2816);
        chk("b_writes", wn - wb, 768);
        check_s("b_final_s", 24'h000001);

        run(24'h000000, 1000, lat, wb, d0);
        chk("busy_latency", lat, 2816);
        chk("busy_writes", wn - wb, 768);
        check_s("busy_final_s", 24'h000000);

        secret_key = 24'h000000;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (1500) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_addr", address_s, 0);
        chk("mid_rst_data", data_s, 0);
        chk("mid_rst_wren", wren_s, 0);
        chk("mid_rst_done", done_task2a, 0);
        @(negedge clk);
        reset_n = 1'b1;
        wn0 = wn;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_no_writes", wn - wn0, 0);
        chk("idle_done_low", done_task2a, 0);

        run(24'h4A2F11, -1, lat, wb, d0);
        chk("k_latency", lat, 2816);
        chk("k_writes", wn - wb, 768);
        check_s("k_final_s", 24'h4A2F11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rc4_ksa_controller.md
Name: rc4_ksa_controller

Overview:
- Upstream neighbour of the PRGA decrypt stage. Implements RC4 key initialisation (task 2a) on the shared 256x8 S working memory.
- Phase 1 writes s[i]=i for i=0..255.
- Phase 2 runs the key schedule: for i=0..255 { j = j + s[i] + key[i mod KEY_BYTES]; swap s[i], s[j] }.
- On completion it raises done_task2a, which enables the decrypt stage.

Parameters:
- KEY_BYTES, 3, number of secret key bytes used cyclically.
- READ_WAIT, 1, wait cycles between presenting a read address and latching q_s. This is 1 for the on-chip RAM with registered address and unregistered output.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to begin; sampled only in IDLE or DONE.
- secret_key  input  8*KEY_BYTES  key; byte 0 = secret_key[8*KEY_BYTES-1 -: 8] (MSB byte first). Must be stable from start until done.
- address_s  output  8  S memory address.
- data_s  output  8  S memory write data.
- wren_s  output  1  S memory write enable.
- q_s  input  8  S memory read data.
- done_task2a  output  1  level high from schedule completion until the next accepted start.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, i=0, j=0, key index=0, si=sj=0. Outputs: address_s=0, data_s=0, wren_s=0, done_task2a=0. Memory contents undefined after a mid-operation reset; no partial-state recovery.
- Outputs decode from state and internal registers only; there is no combinational path from q_s to any output.
- States and transitions:
  - IDLE: start -> INIT, i<=0.
  - INIT: address_s=i, data_s=i, wren_s=1. i increments each cycle. i==255 -> RD_SI with i<=0, j<=0, kidx<=0.
  - RD_SI: address_s=i. Then WAIT_SI for READ_WAIT cycles (address_s held at i).
  - LATCH_SI: si<=q_s.
  - CALC_J: j <= j + si + key[kidx], mod 256 (8-bit wrap).
  - RD_SJ: address_s=j. Then WAIT_SJ for READ_WAIT cycles.
  - LATCH_SJ: sj<=q_s.
  - WR_I: address_s=i, data_s=sj, wren_s=1.
  - WR_J: address_s=j, data_s=si, wren_s=1.
  - NEXT: if i==255 -> DONE; else i<=i+1, kidx wraps at KEY_BYTES-1 to 0 (no modulo operator), -> RD_SI.
  - DONE: done_task2a=1. start -> INIT (done drops on the same edge).
- Cycles per iteration: 8 + 2*READ_WAIT (10 at default).
- Latency at defaults: start sampled at edge E0; INIT occupies 256 cycles; KSA occupies 2560 cycles; done_task2a goes high at edge E0+2816.
- Write counts: exactly 768 wren_s cycles per run (256 init + 512 swap).
- i==j: both swap writes target the same address with the same value; result is correct and no special case is needed.
- start while busy (any state other than IDLE or DONE) is ignored.
- wren_s is never high outside INIT, WR_I and WR_J. The downstream stage may own the memory once done_task2a=1.

Decomposition:
- rc4_pkg:
  - state enum ksa_state_t.
  - S_DEPTH=256.
  - default KEY_BYTES.
  - KEY_W function (8*KEY_BYTES).
- Single module. Key byte selection (secret_key indexed by kidx) is an inline mux; no sub-module is warranted.

Test Plan:
- Init sweep: key 24'h000000, start -> wren_s high for 256 consecutive cycles with address_s=data_s=0,1,...,255 in order, then wren_s=0.
- Zero key schedule: key 24'h000000. First swap pair is WR_I addr0 data0, then WR_J addr0 data0. For i=2 (j=3), writes are addr2 data3 then addr3 data2. Final S matches the software KSA model; done_task2a rises at exactly edge 2816 after start; 768 total writes.
- Byte order: key 24'h000001, i=2 -> j=1+2+1=4, writes addr2 data4 then addr4 data2. Final S matches the model with key bytes {00,00,01}.
- Busy start ignored: pulse start at cycle 1000 of a run -> done timing and final S identical to the uninterrupted run.
- Reset mid-run: drop reset_n during KSA at cycle 1500 -> outputs 0 and state IDLE immediately (asynchronously); a subsequent start with key 24'h4A2F11 completes with S matching the model.
- Restart from DONE: after completion, start with a new key -> done_task2a falls on the start edge and rises again 2816 cycles later; S matches the new-key model.
